// File: rtl/uart_rx_smp.sv
// ============================================================================
// Module      : uart_rx_smp
// Description : Oversampled 8N1 UART receiver driven by an external clk_smp
//               strobe; 3-sample majority vote per bit, start/stop checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_smp #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_smp,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxd_data,
    output logic                 rxd_flag,
    output logic                 frame_err
);

    localparam int c_SMP_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_SMP_W-1:0] c_CNT_LO   = c_SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SMP_W-1:0] c_CNT_MID  = c_SMP_W'(OVERSAMPLE / 2);
    localparam logic [c_SMP_W-1:0] c_CNT_HI   = c_SMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_SMP_W-1:0] c_CNT_LAST = c_SMP_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } t_state;

    t_state               r_state;
    logic                 r_rxd_meta;
    logic                 r_rxd_s;
    logic [c_SMP_W-1:0]   r_smp_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic                 r_vote_a;
    logic                 r_vote_b;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_vote;

    // Synchroniser resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // Third vote sample is the live synchronised value at count M+1.
    assign w_vote = (r_vote_a & r_vote_b) | (r_vote_a & r_rxd_s) | (r_vote_b & r_rxd_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_smp_cnt <= '0;
            r_bit_cnt <= '0;
            r_vote_a  <= 1'b1;
            r_vote_b  <= 1'b1;
            r_shift   <= '0;
            rxd_data  <= '0;
            rxd_flag  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxd_flag  <= 1'b0;
            frame_err <= 1'b0;
            if (clk_smp) begin
                if (r_smp_cnt == c_CNT_LO) begin
                    r_vote_a <= r_rxd_s;
                end
                if (r_smp_cnt == c_CNT_MID) begin
                    r_vote_b <= r_rxd_s;
                end
                case (r_state)
                    S_IDLE: begin
                        // The detecting tick is count 0, so the next tick is count 1.
                        if (!r_rxd_s) begin
                            r_state   <= S_START;
                            r_smp_cnt <= c_SMP_W'(1);
                        end
                    end
                    S_START: begin
                        if ((r_smp_cnt == c_CNT_HI) && w_vote) begin
                            r_state   <= S_IDLE;
                            r_smp_cnt <= '0;
                        end else if (r_smp_cnt == c_CNT_LAST) begin
                            r_state   <= S_DATA;
                            r_smp_cnt <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_smp_cnt <= r_smp_cnt + c_SMP_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (r_smp_cnt == c_CNT_HI) begin
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        end
                        if (r_smp_cnt == c_CNT_LAST) begin
                            r_smp_cnt <= '0;
                            if (r_bit_cnt == c_BIT_LAST) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                            end
                        end else begin
                            r_smp_cnt <= r_smp_cnt + c_SMP_W'(1);
                        end
                    end
                    S_STOP: begin
                        // Decide mid stop bit so a following start edge is not missed.
                        if (r_smp_cnt == c_CNT_HI) begin
                            r_smp_cnt <= '0;
                            if (w_vote) begin
                                rxd_data <= r_shift;
                                rxd_flag <= 1'b1;
                                r_state  <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                r_state   <= S_BREAK;
                            end
                        end else begin
                            r_smp_cnt <= r_smp_cnt + c_SMP_W'(1);
                        end
                    end
                    S_BREAK: begin
                        if (r_rxd_s) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_smp_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_smp.sv
// ============================================================================
// Module      : tb_uart_rx_smp
// Description : Directed self-checking bench for uart_rx_smp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_smp;

    localparam int c_BIT_CLKS = 16 * 27;

    logic       clk;
    logic       rst_n;
    logic       clk_smp;
    logic       rxd;
    logic [7:0] rxd_data;
    logic       rxd_flag;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    int         flag_cnt  = 0;
    int         err_cnt   = 0;
    int         viol      = 0;
    logic       prev_flag = 1'b0;
    logic       prev_err  = 1'b0;
    logic [7:0] data_log [0:63];

    uart_rx_smp #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_smp   (clk_smp),
        .rxd       (rxd),
        .rxd_data  (rxd_data),
        .rxd_flag  (rxd_flag),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        clk_smp = 1'b0;
        forever begin
            repeat (26) @(negedge clk);
            clk_smp = 1'b1;
            @(negedge clk);
            clk_smp = 1'b0;
        end
    end

    // Pulse monitor: logs every received byte and any overlapping or wide pulse.
    always @(negedge clk) begin
        if (rxd_flag === 1'b1) begin
            data_log[flag_cnt[5:0]] <= rxd_data;
            flag_cnt <= flag_cnt + 1;
        end
        if (frame_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
        end
        if ((rxd_flag === 1'b1 && frame_err === 1'b1) ||
            (rxd_flag === 1'b1 && prev_flag) || (frame_err === 1'b1 && prev_err)) begin
            viol <= viol + 1;
        end
        prev_flag <= (rxd_flag === 1'b1);
        prev_err  <= (frame_err === 1'b1);
    end

    task automatic align_tick();
        @(posedge clk);
        while (clk_smp !== 1'b1) @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one frame clock by clock; flip_slot inverts a window around the
    // middle vote sample of that bit slot; clk_limit truncates the frame.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int flip_slot, input int clk_limit);
        logic [9:0] frame;
        int n;
        frame = {stop_val, data, 1'b0};
        n = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < c_BIT_CLKS; c++) begin
                if (n >= clk_limit) return;
                rxd = frame[b] ^ ((b == flip_slot) && (c >= 230) && (c < 250));
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        rxd   = 1'b1;
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rxd_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 00", rxd_data); end
        total++;
        if (rxd_flag !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", rxd_flag); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_basic();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        align_tick();
        send_frame(8'hA5, 1'b1, -1, 10 * c_BIT_CLKS);
        repeat (100) @(negedge clk);
        total++;
        if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL basic_flags: got %0d want 1", flag_cnt - f0); end
        total++;
        if (data_log[f0[5:0]] !== 8'hA5) begin bad++; $display("FAIL basic_log: got %0h want a5", data_log[f0[5:0]]); end
        total++;
        if (rxd_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %0h want a5", rxd_data); end
        total++;
        if (err_cnt - e0 !== 0) begin bad++; $display("FAIL basic_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        align_tick();
        rxd = 1'b0;
        repeat (4 * 27) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * c_BIT_CLKS) @(negedge clk);
        total++;
        if (flag_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_flags: got %0d want 0", flag_cnt - f0); end
        total++;
        if (err_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
        align_tick();
        send_frame(8'h3C, 1'b1, -1, 10 * c_BIT_CLKS);
        repeat (100) @(negedge clk);
        total++;
        if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL glitch_after_flags: got %0d want 1", flag_cnt - f0); end
        total++;
        if (rxd_data !== 8'h3C) begin bad++; $display("FAIL glitch_after_data: got %0h want 3c", rxd_data); end
    endtask

    task automatic test_frame_err();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        align_tick();
        send_frame(8'h12, 1'b1, -1, 10 * c_BIT_CLKS);
        send_frame(8'h00, 1'b0, -1, 10 * c_BIT_CLKS);
        rxd = 1'b0;
        repeat (20 * c_BIT_CLKS) @(negedge clk);
        total++;
        if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", err_cnt - e0); end
        total++;
        if (rxd_data !== 8'h12) begin bad++; $display("FAIL ferr_hold_data: got %0h want 12", rxd_data); end
        total++;
        if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_flags: got %0d want 1", flag_cnt - f0); end
        rxd = 1'b1;
        repeat (c_BIT_CLKS) @(negedge clk);
        align_tick();
        send_frame(8'h55, 1'b1, -1, 10 * c_BIT_CLKS);
        repeat (100) @(negedge clk);
        total++;
        if (rxd_data !== 8'h55) begin bad++; $display("FAIL ferr_next_data: got %0h want 55", rxd_data); end
        total++;
        if (flag_cnt - f0 !== 2) begin bad++; $display("FAIL ferr_next_flags: got %0d want 2", flag_cnt - f0); end
        total++;
        if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_final_count: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int f0, e0;
        logic [7:0] exp [0:2];
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h81;
        f0 = flag_cnt; e0 = err_cnt;
        align_tick();
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, -1, 10 * c_BIT_CLKS);
        repeat (100) @(negedge clk);
        total++;
        if (flag_cnt - f0 !== 3) begin bad++; $display("FAIL b2b_flags: got %0d want 3", flag_cnt - f0); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (data_log[(f0 + i) % 64] !== exp[i]) begin
                bad++; $display("FAIL b2b_data%0d: got %0h want %0h", i, data_log[(f0 + i) % 64], exp[i]);
            end
        end
        total++;
        if (err_cnt - e0 !== 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_noise();
        int f0;
        f0 = flag_cnt;
        align_tick();
        send_frame(8'h0F, 1'b1, 4, 10 * c_BIT_CLKS);
        repeat (100) @(negedge clk);
        total++;
        if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL noise_flags: got %0d want 1", flag_cnt - f0); end
        total++;
        if (rxd_data !== 8'h0F) begin bad++; $display("FAIL noise_data: got %0h want 0f", rxd_data); end
    endtask

    task automatic test_reset_midframe();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        align_tick();
        send_frame(8'hC3, 1'b1, -1, 5 * c_BIT_CLKS + 200);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rxd_data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %0h want 00", rxd_data); end
        total++;
        if (rxd_flag !== 1'b0) begin bad++; $display("FAIL midrst_flag: got %b want 0", rxd_flag); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        rxd   = 1'b1;
        repeat (2 * c_BIT_CLKS) @(negedge clk);
        total++;
        if (flag_cnt - f0 !== 0) begin bad++; $display("FAIL midrst_noflag: got %0d want 0", flag_cnt - f0); end
        align_tick();
        send_frame(8'h7E, 1'b1, -1, 10 * c_BIT_CLKS);
        repeat (100) @(negedge clk);
        total++;
        if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL midrst_after_flags: got %0d want 1", flag_cnt - f0); end
        total++;
        if (rxd_data !== 8'h7E) begin bad++; $display("FAIL midrst_after_data: got %0h want 7e", rxd_data); end
        total++;
        if (err_cnt - e0 !== 0) begin bad++; $display("FAIL midrst_err_count: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_pulse_shape();
        total++;
        if (viol !== 0) begin bad++; $display("FAIL pulse_shape: got %0d bad pulses want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_noise();
        test_reset_midframe();
        test_pulse_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
